simple_bus_seq: RTL
===================

Name: simple_bus_seq

Overview:
- Parametrised successor to the single-command bus target.
- Accepts commands on an en/cmd strobe interface into an internal FIFO.
- Executes commands one at a time: each command runs a cycle counter and then emits a one-cycle done pulse carrying the completed command.
- Adds back-pressure, queue occupancy and overflow detection; sits on the stimulus-facing side of the bus for sequence-driven testing.

Parameters:
- CMD_W, 4, command width in bits.
- FIFO_DEPTH, 4, command queue depth; power of 2, at least 2.
- CNT_W, 4, execution counter width; must be at least CMD_W.
- CNT_MAX, 15, terminal count per command in fixed-length mode; range 0 to 2^CNT_W-1.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_  input  1  reset; synchronous, active-high.
- en  input  1  command strobe; sampled every posedge.
- cmd  input  CMD_W  command value, valid when en=1.
- rdy  output  1  queue not full; equals !full.
- busy  output  1  state is RUN or DONE.
- done  output  1  one-cycle completion pulse.
- done_cmd  output  CMD_W  command just completed; valid while done=1, holds its value otherwise.
- fifo_cnt  output  $clog2(FIFO_DEPTH)+1  number of queued commands.
- overflow  output  1  sticky error flag: a push was attempted while full.

Behaviour:
- Reset (rst_=1 at posedge): FIFO emptied, pointers=0, state=IDLE, cnt=0. Outputs after reset: rdy=1, busy=0, done=0, done_cmd=0, fifo_cnt=0, overflow=0. Reset mid-run aborts the command with no done pulse, and clears overflow.
- Push: en=1 and !full at posedge writes cmd into the FIFO.
- Push while full: command dropped, FIFO unchanged, overflow set to 1 and held until reset.
- Pop and push in the same cycle: both occur; fifo_cnt unchanged. A push into an empty FIFO is not visible to the FSM until the next cycle (no bypass).
- Pointers wrap modulo FIFO_DEPTH. Full/empty are derived from fifo_cnt.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if FIFO not empty, pop head into cmd_ff, set cnt=0, go to RUN. Otherwise stay in IDLE.
  - RUN: each cycle, if cnt==limit go to DONE; else cnt=cnt+1 (width CNT_W, never wraps because limit ≤ 2^CNT_W-1).
  - DONE: done=1 and done_cmd=cmd_ff for exactly this cycle; next state is IDLE.
- limit = CNT_MAX (see Optional Feature for the alternative).
- Latency: push at edge E0 → pop at E1 → done high during the cycle after edge E0+limit+2. With the default of 15, done is observed 17 cycles after acceptance.
- Back-to-back commands: IDLE is one cycle, so the command period is limit+3 cycles.
- en with rdy=0 is legal and never stalls the FSM.

Optional Feature:
- Macro: SIMPLE_BUS_CMD_LEN_EN
- Defined: limit = zero-extended cmd_ff. A cmd value of 0 gives one RUN cycle. CNT_MAX is ignored.
- Undefined: limit = CNT_MAX for every command; cmd is payload only.

Test Plan:
- Reset then single push of cmd=4'hA (default params, macro off) → done=1 for exactly one cycle, 17 cycles after the accept edge; done_cmd=4'hA; busy=1 for cycles 1-17.
- Four pushes on consecutive cycles (4'h1, 4'h2, 4'h3, 4'h4) → dones in order 1,2,3,4, spaced 18 cycles apart; fifo_cnt peaks at 3 (first is popped during the fill); rdy stays 1.
- Six consecutive pushes with the FSM busy (FIFO fills) → rdy=0 once fifo_cnt=4; excess commands dropped; overflow=1 and sticky; only the accepted commands complete.
- Push and pop in the same cycle with fifo_cnt=2 → fifo_cnt stays 2; command order preserved.
- rst_=1 asserted for one cycle while cnt=7 in RUN with 2 commands queued → no done pulse; all outputs at reset values the next cycle; a new push of 4'h5 completes normally.
- SIMPLE_BUS_CMD_LEN_EN defined: push cmd=4'h0 → done 2 cycles after the accept edge; push cmd=4'h3 → done 5 cycles after the accept edge.

Source files
------------

// File: rtl/simple_bus_seq.sv
// Queued command sequencer: commands enter a FIFO, run a cycle counter each, then pulse done.
// Optional macro SIMPLE_BUS_CMD_LEN_EN: per-command run length taken from the command value.
module simple_bus_seq #(
  parameter int unsigned CMD_W      = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned CNT_MAX    = 15
) (
  input  logic                          clk,
  input  logic                          rst_,
  input  logic                          en,
  input  logic [CMD_W-1:0]              cmd,
  output logic                          rdy,
  output logic                          busy,
  output logic                          done,
  output logic [CMD_W-1:0]              done_cmd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          overflow
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]   limit;
  logic [CMD_W-1:0]   cmd_ff;
  logic [CMD_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [FCNT_W-1:0]  fcnt_nxt;
  logic               full, empty, push, pop;

  assign full  = (fifo_cnt == FCNT_W'(FIFO_DEPTH));
  assign empty = (fifo_cnt == '0);
  assign push  = en && !full;

`ifdef SIMPLE_BUS_CMD_LEN_EN
  assign limit = CNT_W'(cmd_ff);
`else
  assign limit = CNT_W'(CNT_MAX);
`endif

  // Next-state, counter and pop decision
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == limit) state_nxt = DONE;
        else              cnt_nxt   = cnt + CNT_W'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Occupancy after this cycle's push/pop
  always_comb begin
    fcnt_nxt = fifo_cnt;
    case ({push, pop})
      2'b10:   fcnt_nxt = fifo_cnt + FCNT_W'(1);
      2'b01:   fcnt_nxt = fifo_cnt - FCNT_W'(1);
      default: fcnt_nxt = fifo_cnt;
    endcase
  end

  // Queue storage needs no reset; occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd;
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state    <= IDLE;
      cnt      <= '0;
      cmd_ff   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
      rdy      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      done_cmd <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      fifo_cnt <= fcnt_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        cmd_ff <= mem[rd_ptr];
      end
      if (en && full) overflow <= 1'b1;
      // Status outputs are registered from the next-state values
      rdy  <= (fcnt_nxt != FCNT_W'(FIFO_DEPTH));
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == DONE);
      if (state_nxt == DONE) done_cmd <= cmd_ff;
    end
  end

endmodule
